// File: rtl/decoder_5to32.sv
// -----------------------------------------------------------------------------
// decoder_5to32
//   Enable-gated binary-to-one-hot decoder. Converts an IN_W-bit unsigned
//   index into a 2**IN_W-bit one-hot select vector. With the default
//   IN_W=5 it drives the 32 write selects of the register file.
//
//   Select bit k is high iff enable=1 and in==k. At most one bit is ever
//   high: exactly one while enabled, none while disabled. Every index value
//   is legal, so there is no out-of-range case.
//
//   REG_OUT=0 : select follows the inputs combinationally (zero latency).
//               clk and reset_n are unused and there is no state.
//   REG_OUT=1 : select is registered on the rising edge of clk (one-cycle
//               latency). A low reset_n clears select on that edge and wins
//               over enable. The value before the first reset edge is
//               undefined.
//
// Parameters
//   IN_W     width of the index input; the select output is 2**IN_W wide
//   REG_OUT  0 = combinational select, 1 = registered select
//
// Ports
//   clk      in   1         system clock (used only when REG_OUT=1)
//   reset_n  in   1         synchronous active-low reset (REG_OUT=1 only)
//   enable   in   1         decode enable; 0 forces every select low
//   in       in   IN_W      binary index to decode (unsigned)
//   select   out  2**IN_W   one-hot select; bit 0 <-> in==0, MSB <-> max index
// -----------------------------------------------------------------------------
module decoder_5to32 #(
  parameter int IN_W    = 5,
  parameter bit REG_OUT = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [IN_W-1:0]      in,
  output logic [2**IN_W-1:0]   select
);

  localparam int OUT_W = 2**IN_W;

  logic [OUT_W-1:0] decoded;

  // The index is exactly IN_W bits wide, so it always addresses a bit of
  // decoded; enable gates the single bit that gets set.
  always_comb begin
    // NOTE: assigning a default before any conditional write keeps this
    // block purely combinational; without it a disabled decode would have to
    // hold its old value and a latch would be inferred.
    decoded = '0;
    if (enable) begin
      decoded[in] = 1'b1;
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [OUT_W-1:0] select_q;

      // Reset is checked first so it overrides any enabled decode on the
      // same edge; decoding resumes on the first edge with reset_n high.
      always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge value of decoded, independent of block ordering.
        if (!reset_n) begin
          select_q <= '0;
        end else begin
          select_q <= decoded;
        end
      end

      assign select = select_q;
    end else begin : g_comb
      // Clock and reset have no function in the combinational build; fold
      // them into a deliberately unused net so they are visibly accounted for.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset_n;

      assign select = decoded;
    end
  endgenerate

endmodule

// File: tb/tb_decoder_5to32.sv
// -----------------------------------------------------------------------------
// tb_decoder_5to32
//   Self-checking bench for decoder_5to32. Two instances are exercised:
//   dut_c (REG_OUT=0, combinational) and dut_r (REG_OUT=1, registered).
//   A table of {enable, in, expected select} records drives both modes,
//   followed by hand-written multi-cycle sequences for the registered build
//   and a randomized one-hot property sweep.
// -----------------------------------------------------------------------------
module tb_decoder_5to32;

  localparam int IN_W  = 5;
  localparam int OUT_W = 32;

  typedef struct {
    logic             en;
    logic [IN_W-1:0]  idx;
    logic [OUT_W-1:0] exp;
  } vec_t;

  logic             clk;
  logic             clk_run;

  logic             c_enable;
  logic [IN_W-1:0]  c_in;
  logic [OUT_W-1:0] c_select;

  logic             r_reset_n;
  logic             r_enable;
  logic [IN_W-1:0]  r_in;
  logic [OUT_W-1:0] r_select;

  int n_cmp;
  int n_fail;

  vec_t vecs[$];

  decoder_5to32 #(.IN_W(IN_W), .REG_OUT(1'b0)) dut_c (
    .clk     (clk),
    .reset_n (1'b1),
    .enable  (c_enable),
    .in      (c_in),
    .select  (c_select)
  );

  decoder_5to32 #(.IN_W(IN_W), .REG_OUT(1'b1)) dut_r (
    .clk     (clk),
    .reset_n (r_reset_n),
    .enable  (r_enable),
    .in      (r_in),
    .select  (r_select)
  );

  // Clock can be frozen to show the combinational path needs no edges.
  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic check(input string name, input logic [OUT_W-1:0] act,
                       input logic [OUT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge, with a time bound.
  task automatic tick();
    fork
      begin : wait_edge
        @(posedge clk);
      end
      begin : timeout
        #100;
        n_cmp++;
        n_fail++;
        $display("FAIL clock_timeout: got no edge, expected an edge within 100");
      end
    join_any
    disable fork;
    #1;
  endtask

  function automatic int bit_pos(input logic [OUT_W-1:0] v);
    int p;
    p = -1;
    for (int k = 0; k < OUT_W; k++) begin
      if (v[k]) p = k;
    end
    return p;
  endfunction

  initial begin
    vec_t v;
    int   rnd_en;
    int   rnd_idx;

    n_cmp     = 0;
    n_fail    = 0;
    clk_run   = 1'b0;
    c_enable  = 1'b0;
    c_in      = '0;
    r_reset_n = 1'b0;
    r_enable  = 1'b0;
    r_in      = '0;

    // ---- vector table: hand-written anchors, then full sweeps ----
    vecs.push_back('{1'b1, 5'd0,  32'h0000_0001});
    vecs.push_back('{1'b1, 5'd31, 32'h8000_0000});
    vecs.push_back('{1'b1, 5'd5,  32'h0000_0020});
    vecs.push_back('{1'b1, 5'd12, 32'h0000_1000});
    vecs.push_back('{1'b1, 5'd16, 32'h0001_0000});
    vecs.push_back('{1'b1, 5'd30, 32'h4000_0000});
    for (int i = 0; i < OUT_W; i++) begin
      v.en  = 1'b1;
      v.idx = IN_W'(i);
      v.exp = 32'h1 << i;
      vecs.push_back(v);
    end
    for (int i = OUT_W - 1; i >= 0; i--) begin
      v.en  = 1'b0;
      v.idx = IN_W'(i);
      v.exp = 32'h0;
      vecs.push_back(v);
    end

    // ---- REG_OUT=0: apply table with the clock stopped, 10-unit steps ----
    for (int i = 0; i < vecs.size(); i++) begin
      c_enable = vecs[i].en;
      c_in     = vecs[i].idx;
      #10;
      check($sformatf("comb_vec%0d_en%0d_in%0d", i, vecs[i].en, vecs[i].idx),
            c_select, vecs[i].exp);
    end

    // ---- REG_OUT=0: enable toggle with no clock activity ----
    c_enable = 1'b1;
    c_in     = 5'd12;
    #10;
    check("comb_toggle_on", c_select, 32'h0000_1000);
    c_enable = 1'b0;
    #1;
    check("comb_toggle_off", c_select, 32'h0);
    c_enable = 1'b1;
    #1;
    check("comb_toggle_on_again", c_select, 32'h0000_1000);

    // ---- REG_OUT=1: reset held for two edges with enable=1, in=7 ----
    clk_run   = 1'b1;
    r_reset_n = 1'b0;
    r_enable  = 1'b1;
    r_in      = 5'd7;
    tick();
    tick();
    check("reg_reset_held", r_select, 32'h0);
    r_reset_n = 1'b1;
    #1;
    check("reg_reset_release_before_edge", r_select, 32'h0);
    tick();
    check("reg_after_release", r_select, 32'h0000_0080);

    // ---- REG_OUT=1: index 3 -> 4 between edges ----
    r_in = 5'd3;
    tick();
    check("reg_in3", r_select, 32'h0000_0008);
    r_in = 5'd4;
    #2;
    check("reg_in4_before_edge", r_select, 32'h0000_0008);
    tick();
    check("reg_in4_after_edge", r_select, 32'h0000_0010);

    // ---- REG_OUT=1: reset mid-stream clears on that edge, then resumes ----
    r_reset_n = 1'b0;
    tick();
    check("reg_midstream_reset", r_select, 32'h0);
    r_reset_n = 1'b1;
    tick();
    check("reg_resume", r_select, 32'h0000_0010);

    // ---- REG_OUT=1: enable 1->0 drops the bit on the next edge ----
    r_enable = 1'b0;
    #1;
    check("reg_disable_before_edge", r_select, 32'h0000_0010);
    tick();
    check("reg_disable_after_edge", r_select, 32'h0);

    // ---- REG_OUT=1: table replay, one edge per vector ----
    for (int i = 0; i < vecs.size(); i++) begin
      r_enable = vecs[i].en;
      r_in     = vecs[i].idx;
      tick();
      check($sformatf("reg_vec%0d_en%0d_in%0d", i, vecs[i].en, vecs[i].idx),
            r_select, vecs[i].exp);
    end

    // ---- both modes: randomized one-hot property sweep ----
    for (int i = 0; i < 1000; i++) begin
      rnd_en   = int'($urandom_range(1, 0));
      rnd_idx  = int'($urandom_range(OUT_W - 1, 0));
      c_enable = rnd_en[0];
      c_in     = IN_W'(rnd_idx);
      r_enable = rnd_en[0];
      r_in     = IN_W'(rnd_idx);
      tick();
      check($sformatf("comb_rand%0d_pop", i), 32'($countones(c_select)),
            32'(rnd_en));
      check($sformatf("reg_rand%0d_pop", i), 32'($countones(r_select)),
            32'(rnd_en));
      if (rnd_en != 0) begin
        check($sformatf("comb_rand%0d_pos", i), 32'(bit_pos(c_select)),
              32'(rnd_idx));
        check($sformatf("reg_rand%0d_pos", i), 32'(bit_pos(r_select)),
              32'(rnd_idx));
      end
    end

    clk_run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
